// File: rtl/maxpool_pkg.sv
// Shared constants, bank selects and FSM state type for the
// layer-0 conv stage and the 2x2 max-pooling stage.
package maxpool_pkg;

  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int AW    = 12;

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/maxpool_addr_gen.sv
// Window counters (r,c,k) for 2x2/stride-2 pooling; produces the
// layer-0 read address, layer-1 write address and end-of-window flags.
module maxpool_addr_gen
  import maxpool_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_k_inc,
  input  logic          i_win_adv,
  output logic [AW-1:0] o_addr_rd,
  output logic [AW-1:0] o_addr_wr,
  output logic          o_k_last,
  output logic          o_out_last
);

  localparam int CW = $clog2(IMG_W) - 1;

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [1:0]    r_k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else begin
      if (i_k_inc)
        r_k <= r_k + 2'd1;
      if (i_win_adv) begin
        r_col <= r_col + 1'b1;
        if (&r_col)
          r_row <= r_row + 1'b1;
      end
    end
  end

  // row = 2r + k[1], col = 2c + k[0]; IMG_W is a power of two
  assign o_addr_rd  = {r_row, r_k[1], r_col, r_k[0]};
  assign o_addr_wr  = {{(AW - 2*CW){1'b0}}, r_row, r_col};
  assign o_k_last   = (r_k == 2'd3);
  assign o_out_last = (&r_row) & (&r_col);

endmodule

// File: rtl/maxpool_engine.sv
// 2x2/stride-2 max-pool of the 64x64 layer-0 map into layer-1.
// Define MAXPOOL_SIGNED_EN for a two's-complement compare.
module maxpool_engine
  import maxpool_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  state_t        r_state;
  state_t        w_next;
  logic          r_cap;
  logic          r_cap_first;
  logic [DW-1:0] r_max;
  logic          w_gt;
  logic          w_clr;
  logic          w_k_inc;
  logic          w_win_adv;
  logic          w_k_last;
  logic          w_out_last;

  maxpool_addr_gen u_addr (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_k_inc    (w_k_inc),
    .i_win_adv  (w_win_adv),
    .o_addr_rd  (caddr_rd),
    .o_addr_wr  (caddr_wr),
    .o_k_last   (w_k_last),
    .o_out_last (w_out_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    crd       = 1'b0;
    cwr       = 1'b0;
    csel      = CSEL_IDLE;
    cdata_wr  = '0;
    w_clr     = 1'b0;
    w_k_inc   = 1'b0;
    w_win_adv = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (ready) begin
          w_next = READ;
          w_clr  = 1'b1;
        end
      end
      READ: begin
        crd     = 1'b1;
        csel    = CSEL_L0;
        w_k_inc = 1'b1;
        if (w_k_last)
          w_next = LAST;
      end
      LAST: begin
        csel   = CSEL_L0;
        w_next = WRITE;
      end
      WRITE: begin
        cwr       = 1'b1;
        csel      = CSEL_L1;
        cdata_wr  = r_max;
        w_win_adv = 1'b1;
        w_next    = w_out_last ? DONE : READ;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef MAXPOOL_SIGNED_EN
  assign w_gt = $signed(cdata_rd) > $signed(r_max);
`else
  assign w_gt = cdata_rd > r_max;
`endif

  // Read data arrives one cycle after issue; first word of a window
  // is the one whose predecessor cycle had no read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap       <= 1'b0;
      r_cap_first <= 1'b0;
      r_max       <= '0;
    end else begin
      r_cap       <= crd;
      r_cap_first <= crd & ~r_cap;
      if (r_cap && (r_cap_first || w_gt))
        r_max <= cdata_rd;
    end
  end

endmodule

// File: tb/tb_maxpool_engine.sv
// Directed self-checking bench for maxpool_engine with a shared
// layer-0/layer-1 memory model.
module tb_maxpool_engine;
  import maxpool_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0 [4096];
  logic [DW-1:0] l1 [1024];
  int            wr_cnt = 0;
  int            viol = 0;
  logic          rd_log_en = 1'b0;
  logic [AW-1:0] rd_q [$];
  int            n_chk = 0;
  int            n_pass = 0;

  maxpool_engine dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (crd)
      cdata_rd <= l0[caddr_rd];
    else
      cdata_rd <= 'x;
    if (cwr) begin
      l1[caddr_wr[9:0]] = cdata_wr;
      wr_cnt = wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (crd && cwr) viol = viol + 1;
      if (crd && csel !== 3'b001) viol = viol + 1;
      if (cwr && csel !== 3'b011) viol = viol + 1;
      if (crd && rd_log_en && rd_q.size() < 8)
        rd_q.push_back(caddr_rd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 4096; i++) l0[i] = DW'(i);
  endtask

  task automatic check_ramp(input string tag);
    int errs;
    logic [DW-1:0] e;
    errs = 0;
    for (int j = 0; j < 1024; j++) begin
      e = DW'((2 * (j / 32) + 1) * 64 + 2 * (j % 32) + 1);
      if (l1[j] !== e) errs++;
    end
    check(tag, errs, 0);
  endtask

  // pulse ready, return edges from start edge to busy-low edge
  task automatic run_job(input int pulse_at, output int cyc,
                         output logic b1);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    ready = 1'b0;
    b1 = busy;
    while (busy === 1'b1 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      #1;
      ready = (cyc == pulse_at);
    end
    ready = 1'b0;
  endtask

  task automatic put_win(input int j, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] c,
                         input logic [DW-1:0] d);
    l0[2*j]      = a;
    l0[2*j+1]    = b;
    l0[64+2*j]   = c;
    l0[64+2*j+1] = d;
  endtask

  initial begin
    int cyc;
    int base;
    logic b1;
    logic [AW-1:0] exp_rd [8];
    logic [DW-1:0] exp_sgn;

    exp_rd = '{12'd0, 12'd1, 12'd64, 12'd65,
               12'd2, 12'd3, 12'd66, 12'd67};
    reset = 1'b1;
    ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {crd, cwr}, 0);
    check("rst_csel", csel, 0);
    check("rst_addr", {caddr_rd, caddr_wr}, 0);
    check("rst_wdata", cdata_wr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    load_ramp();
    rd_log_en = 1'b1;
    base = wr_cnt;
    run_job(0, cyc, b1);
    rd_log_en = 1'b0;
    check("ramp_busy_rise", b1, 1);
    check("ramp_cycles", cyc, 6146);
    check("ramp_writes", wr_cnt - base, 1024);
    check("ramp_l1_0", l1[0], 65);
    check("ramp_l1_1023", l1[1023], 4095);
    check_ramp("ramp_image");
    check("rd_q_len", rd_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rd_addr_%0d", i),
            (i < rd_q.size()) ? rd_q[i] : 'x, exp_rd[i]);

    for (int i = 0; i < 4096; i++) l0[i] = '0;
    put_win(0, 20'h0ABCD, 20'h00001, 20'h00001, 20'h00001);
    put_win(1, 20'h00001, 20'h0ABCD, 20'h00001, 20'h00001);
    put_win(2, 20'h00001, 20'h00001, 20'h0ABCD, 20'h00001);
    put_win(3, 20'h00001, 20'h00001, 20'h00001, 20'h0ABCD);
    put_win(4, 20'h00005, 20'h00005, 20'h00005, 20'h00005);
    put_win(5, 20'hFFFFF, 20'h00003, 20'h80000, 20'h00000);
    put_win(6, 20'h00009, 20'h00003, 20'h00007, 20'h00008);
    run_job(0, cyc, b1);
    check("win_cycles", cyc, 6146);
    check("win_k0", l1[0], 20'h0ABCD);
    check("win_k1", l1[1], 20'h0ABCD);
    check("win_k2", l1[2], 20'h0ABCD);
    check("win_k3", l1[3], 20'h0ABCD);
    check("win_tie", l1[4], 20'h00005);
`ifdef MAXPOOL_SIGNED_EN
    exp_sgn = 20'h00003;
`else
    exp_sgn = 20'hFFFFF;
`endif
    check("win_sign", l1[5], exp_sgn);
    check("win_desc", l1[6], 20'h00009);
    check("win_zero", l1[7], 20'h00000);

    load_ramp();
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (99) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {crd, cwr}, 0);
    check("mid_rst_csel", csel, 0);
    check("mid_rst_addr", {caddr_rd, caddr_wr}, 0);
    check("mid_rst_wdata", cdata_wr, 0);
    check("mid_rst_partial", l1[0], 65);
    check("mid_rst_untouched", l1[1000], 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    run_job(0, cyc, b1);
    check("rerun_writes", wr_cnt - base, 1024);
    check_ramp("rerun_image");

    base = wr_cnt;
    run_job(50, cyc, b1);
    check("pulse_cycles", cyc, 6146);
    check("pulse_writes", wr_cnt - base, 1024);
    repeat (3) @(negedge clk);
    check("pulse_no_restart", busy, 0);

    base = wr_cnt;
    @(negedge clk);
    ready = 1'b1;
    cyc = 0;
    @(posedge clk);
    #1;
    while (busy === 1'b1 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("held_first_end", busy, 0);
    @(posedge clk);
    #1;
    check("held_restart", busy, 1);
    ready = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("held_second_end", busy, 0);
    check("held_writes", wr_cnt - base, 2048);
    check("protocol", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
